// File: rtl/move_sequencer_pkg.sv
// Shared move-code definitions for the sequencer, solver and executor.
// Codes: R=2 .. Di=13 face turns, NULL=15 no-op; 0, 1 and 14 are illegal.
package move_sequencer_pkg;

  localparam logic [3:0] MV_R    = 4'd2;
  localparam logic [3:0] MV_RI   = 4'd3;
  localparam logic [3:0] MV_U    = 4'd4;
  localparam logic [3:0] MV_UI   = 4'd5;
  localparam logic [3:0] MV_F    = 4'd6;
  localparam logic [3:0] MV_FI   = 4'd7;
  localparam logic [3:0] MV_L    = 4'd8;
  localparam logic [3:0] MV_LI   = 4'd9;
  localparam logic [3:0] MV_B    = 4'd10;
  localparam logic [3:0] MV_BI   = 4'd11;
  localparam logic [3:0] MV_D    = 4'd12;
  localparam logic [3:0] MV_DI   = 4'd13;
  localparam logic [3:0] MV_NULL = 4'd15;

  localparam int unsigned FACE_R = 0;
  localparam int unsigned FACE_U = 1;
  localparam int unsigned FACE_F = 2;
  localparam int unsigned FACE_L = 3;
  localparam int unsigned FACE_B = 4;
  localparam int unsigned FACE_D = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_SETTLE    = 3'd5
  } seq_state_e;

  function automatic logic is_valid_move(input logic [3:0] m);
    return (m >= MV_R) && (m <= MV_DI);
  endfunction

endpackage

// File: rtl/move_sequencer_fifo.sv
// move_fifo: DEPTH x 4 move queue with occupancy count and synchronous flush.
// Ports: clock/reset_n; flush_i clears the queue and drops a same-cycle push;
//        push_i/din_i enqueue when not full; pop_i dequeues when not empty;
//        dout_o is the current head; count_o, full_o, empty_o report occupancy.
// The head is presented combinationally; the sequencer's move register is
// the registered read stage.
module move_fifo #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [3:0]               din_i,
  input  logic                     pop_i,
  output logic [3:0]               dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: buffers solver move codes and issues them one at a time to
// the stepper executor, waiting for completion plus a settle gap between moves.
// Ports: clock, reset_n (async active-low); in_move/in_valid/in_ready enqueue;
//        run enables issuing; abort flushes the queue and ends after the
//        in-flight move; next_move/move_start present a move; move_done is the
//        executor idle flag; busy, queue_count, moves_issued, bad_move status.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned SETTLE_CYCLES = 5_000_000,
  parameter int unsigned BUSY_TIMEOUT  = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [3:0]             in_move,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   run,
  input  logic                   abort,
  output logic [3:0]             next_move,
  output logic                   move_start,
  input  logic                   move_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic [15:0]            moves_issued,
  output logic                   bad_move
);
  localparam int unsigned SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam int unsigned TW          = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam int unsigned TMAX        = (BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0;

  seq_state_e  state_q, state_d;
  logic [3:0]  move_q, move_d;
  logic [3:0]  next_move_q, next_move_d;
  logic [15:0] issued_q, issued_d;
  logic        bad_q, bad_d;
  logic        aborted_q, aborted_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [SW-1:0] settle_q, settle_d;

  logic        pop;
  logic [3:0]  fifo_head;
  logic        fifo_full, fifo_empty;

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush_i (abort),
    .push_i  (in_valid),
    .din_i   (in_move),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .count_o (queue_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready     = !fifo_full;
  assign move_start   = (state_q == ST_ISSUE);
  assign busy         = (state_q != ST_IDLE);
  assign next_move    = next_move_q;
  assign moves_issued = issued_q;
  assign bad_move     = bad_q;

  always_comb begin
    state_d     = state_q;
    move_d      = move_q;
    next_move_d = next_move_q;
    issued_d    = issued_q;
    bad_d       = bad_q;
    aborted_d   = aborted_q | abort;
    tmr_d       = tmr_q;
    settle_d    = settle_q;
    pop         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        aborted_d = 1'b0;
        // abort flushes the FIFO this cycle, so the head is not a real entry.
        if (run && !fifo_empty && move_done && !abort) begin
          pop     = 1'b1;
          move_d  = fifo_head;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (move_q == MV_NULL) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b0;
        end else if (!is_valid_move(move_q)) begin
          bad_d     = 1'b1;
          state_d   = ST_IDLE;
          aborted_d = 1'b0;
        end else begin
          next_move_d = move_q;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issued_d = issued_q + 16'd1;
        tmr_d    = '0;
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!move_done || tmr_q == TW'(TMAX)) state_d = ST_WAIT_DONE;
        else                                  tmr_d   = tmr_q + TW'(1);
      end
      ST_WAIT_DONE: begin
        if (move_done) begin
          if (abort || aborted_q || SETTLE_CYCLES == 0) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b0;
          end else begin
            settle_d = SW'(SETTLE_LOAD);
            state_d  = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (abort || settle_q == '0) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b0;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        aborted_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      move_q      <= MV_NULL;
      next_move_q <= MV_NULL;
      issued_q    <= '0;
      bad_q       <= 1'b0;
      aborted_q   <= 1'b0;
      tmr_q       <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      move_q      <= move_d;
      next_move_q <= next_move_d;
      issued_q    <= issued_d;
      bad_q       <= bad_d;
      aborted_q   <= aborted_d;
      tmr_q       <= tmr_d;
      settle_q    <= settle_d;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a simple executor model.
module tb_move_sequencer;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned SETTLE   = 20;
  localparam int unsigned BTO      = 16;
  localparam int          BUSY_LEN = 100;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in_move = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       run = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] next_move;
  logic       move_start;
  logic       move_done = 1'b1;
  logic       busy;
  logic [3:0] queue_count;
  logic [15:0] moves_issued;
  logic       bad_move;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int busy_cnt = 0;
  bit exec_drop = 1'b1;
  logic [3:0] log_mv [64];
  int         log_cyc [64];

  move_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .BUSY_TIMEOUT(BTO)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_move      (in_move),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .run          (run),
    .abort        (abort),
    .next_move    (next_move),
    .move_start   (move_start),
    .move_done    (move_done),
    .busy         (busy),
    .queue_count  (queue_count),
    .moves_issued (moves_issued),
    .bad_move     (bad_move)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Executor: drops move_done for BUSY_LEN clocks after each strobe.
  always @(negedge clock) begin
    if (move_start) begin
      if (pulse_cnt < 64) begin
        log_mv[pulse_cnt]  = next_move;
        log_cyc[pulse_cnt] = cyc;
      end
      pulse_cnt = pulse_cnt + 1;
      if (exec_drop) busy_cnt = BUSY_LEN;
    end
    if (busy_cnt > 0) begin
      move_done = 1'b0;
      busy_cnt  = busy_cnt - 1;
    end else begin
      move_done = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [3:0] code);
    in_move  = code;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    run = 1'b0; abort = 1'b0; in_valid = 1'b0;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_pulses(input string tag, input int n, input int limit);
    int k = 0;
    while (pulse_cnt < n && k < limit) begin
      @(negedge clock);
      k++;
    end
    chk(tag, pulse_cnt >= n, 1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    while (busy !== 1'b0 && k < limit) begin
      @(negedge clock);
      k++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    int base;
    int t_idle;
    int k;

    // Reset values
    tick(2);
    chk("rst_next_move", next_move, 15);
    chk("rst_move_start", move_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_queue_count", queue_count, 0);
    chk("rst_moves_issued", moves_issued, 0);
    chk("rst_bad_move", bad_move, 0);
    chk("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    tick(1);

    // 1: R, Ui, F issued in order with settle gaps
    run = 1'b1;
    push(4'd2); push(4'd5); push(4'd6);
    wait_pulses("t1_pulses", 3, 1000);
    wait_idle("t1_idle", 400);
    chk("t1_mv0", log_mv[0], 2);
    chk("t1_mv1", log_mv[1], 5);
    chk("t1_mv2", log_mv[2], 6);
    chk("t1_issued", moves_issued, 3);
    chk("t1_gap01", (log_cyc[1] - log_cyc[0]) >= BUSY_LEN + SETTLE, 1);
    chk("t1_gap12", (log_cyc[2] - log_cyc[1]) >= BUSY_LEN + SETTLE, 1);

    // 2: NULL skipped, invalid flagged, valid issued
    do_reset();
    base = pulse_cnt;
    run = 1'b1;
    push(4'd15); push(4'd0); push(4'd4);
    wait_pulses("t2_pulse", base + 1, 200);
    wait_idle("t2_idle", 400);
    tick(5);
    chk("t2_pulses", pulse_cnt - base, 1);
    chk("t2_mv", log_mv[base], 4);
    chk("t2_bad", bad_move, 1);
    chk("t2_issued", moves_issued, 1);

    // 3: full FIFO, overflow push ignored, push+pop at DEPTH-1
    do_reset();
    base = pulse_cnt;
    chk("t3_bad_cleared", bad_move, 0);
    for (int i = 0; i < int'(DEPTH); i++) push(4'(i + 2));
    chk("t3_full_ready", in_ready, 0);
    chk("t3_full_count", queue_count, DEPTH);
    push(4'd3);
    chk("t3_overflow_count", queue_count, DEPTH);
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    chk("t3_pop_count", queue_count, DEPTH - 1);
    wait_pulses("t3_pulse1", base + 1, 50);
    wait_idle("t3_idle1", 400);
    tick(10);
    chk("t3_halt_count", queue_count, DEPTH - 1);
    chk("t3_halt_pulses", pulse_cnt - base, 1);
    run = 1'b1; in_valid = 1'b1; in_move = 4'd10;
    @(negedge clock);
    run = 1'b0; in_valid = 1'b0;
    chk("t3_pushpop_count", queue_count, DEPTH - 1);
    chk("t3_pushpop_ready", in_ready, 1);
    wait_pulses("t3_pulse2", base + 2, 50);
    wait_idle("t3_idle2", 400);
    chk("t3_issued", moves_issued, 2);
    chk("t3_mv", log_mv[base + 1], 3);

    // 4: move_done never drops -> busy timeout then settle
    do_reset();
    base = pulse_cnt;
    exec_drop = 1'b0;
    run = 1'b1;
    push(4'd2); push(4'd3);
    wait_pulses("t4_pulses", base + 2, 300);
    wait_idle("t4_idle", 300);
    chk("t4_mv0", log_mv[base], 2);
    chk("t4_mv1", log_mv[base + 1], 3);
    chk("t4_gap", log_cyc[base + 1] - log_cyc[base], 2 + BTO + SETTLE + 2);
    exec_drop = 1'b1;

    // 5: abort in WAIT_DONE with 5 queued
    do_reset();
    base = pulse_cnt;
    run = 1'b1;
    for (int i = 0; i < 6; i++) push(4'(i + 2));
    wait_pulses("t5_pulse", base + 1, 50);
    tick(10);
    chk("t5_queued", queue_count, 5);
    abort = 1'b1; in_valid = 1'b1; in_move = 4'd7;
    @(negedge clock);
    abort = 1'b0; in_valid = 1'b0;
    chk("t5_flushed", queue_count, 0);
    k = 0;
    while (busy !== 1'b0 && k < 300) begin
      @(negedge clock);
      k++;
    end
    t_idle = cyc;
    chk("t5_idle", busy, 0);
    chk("t5_no_settle", t_idle - log_cyc[base], BUSY_LEN + 1);
    tick(60);
    chk("t5_pulses", pulse_cnt - base, 1);
    chk("t5_issued", moves_issued, 1);
    chk("t5_count_after", queue_count, 0);

    // 6: async reset in WAIT_DONE, then normal issue of L
    do_reset();
    base = pulse_cnt;
    run = 1'b1;
    push(4'd12); push(4'd9);
    wait_pulses("t6_pulse", base + 1, 50);
    tick(20);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_start", move_start, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_next", next_move, 15);
    chk("t6_rst_issued", moves_issued, 0);
    chk("t6_rst_count", queue_count, 0);
    chk("t6_rst_ready", in_ready, 1);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    base = pulse_cnt;
    push(4'd8);
    wait_pulses("t6_pulse_l", base + 1, 300);
    wait_idle("t6_idle", 400);
    chk("t6_mv", log_mv[base], 8);
    chk("t6_issued", moves_issued, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
